// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch stage: issues sequential word-aligned reads on the
// instruction memory port, buffers returned words with their PCs in a small
// FIFO and presents them to the decoder over a valid/ready handshake.
// A redirect flushes the buffer and restarts fetching at the new PC.
module fetch_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fetch_en,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_wdata,
    input  logic [31:0]                mem_rdata,
    input  logic                       mem_ready,
    output logic                       instr_valid,
    output logic [31:0]                instr_data,
    output logic [31:0]                instr_pc,
    input  logic                       instr_ready,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {
        S_WAIT,
        S_RUN
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    fetch_pc;
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count_q;
    logic [31:0]    pc_mem   [DEPTH];
    logic [31:0]    data_mem [DEPTH];
    logic           push, pop;

    // State register: WAIT after reset, RUN from the first edge after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_WAIT;
        else        state_q <= state_d;
    end

    // Next-state and request/handshake decode
    always_comb begin
        state_d = state_q;
        if (state_q == S_WAIT) state_d = S_RUN;
        // Fullness is judged on the registered count, so a same-cycle pop
        // never makes room for a push.
        mem_req = (state_q == S_RUN) && fetch_en && !redirect_valid &&
                  (count_q < CW'(DEPTH));
        push    = mem_req && mem_ready;
        pop     = instr_valid && instr_ready && !redirect_valid;
    end

    // Fetch address, FIFO pointers and entry count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC & ~32'd3;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~32'd3;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
                wr_ptr   <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage: each completed transfer stores its word with its PC
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= fetch_pc;
            data_mem[wr_ptr] <= mem_rdata;
        end
    end

    assign mem_we      = 1'b0;
    assign mem_wdata   = '0;
    assign mem_addr    = fetch_pc;
    assign instr_valid = (count_q != '0);
    assign instr_data  = data_mem[rd_ptr];
    assign instr_pc    = pc_mem[rd_ptr];
    assign occupancy   = count_q;

endmodule
